// File: rtl/fp_mul_pkg.sv
// Shared definitions for the IEEE-754 multiplier special-case front end:
// status bit positions, the per-stage metadata record and the canonical qNaN builder.
package fp_mul_pkg;

  // Operand status bit positions: {nan, inf, denormal, normal, zero}
  localparam int unsigned ST_ZERO   = 0;
  localparam int unsigned ST_NORMAL = 1;
  localparam int unsigned ST_DENORM = 2;
  localparam int unsigned ST_INF    = 3;
  localparam int unsigned ST_NAN    = 4;

  // Operation status bit positions: {nan, clear_inf, zero, invalid}
  localparam int unsigned OP_INVALID = 0;
  localparam int unsigned OP_ZERO    = 1;
  localparam int unsigned OP_INF     = 2;
  localparam int unsigned OP_NAN     = 3;

  // Classification results carried down the pipeline alongside the result word.
  // denorm_in is the raw denormal indication, kept even when DAZ folds it to zero.
  typedef struct packed {
    logic [4:0] st1;
    logic [4:0] st2;
    logic [3:0] ops;
    logic       denorm_in;
  } stage_meta_t;

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set, rest zero.
  function automatic logic [63:0] make_qnan(input int unsigned exp_w, input int unsigned mant_w);
    logic [63:0] q;
    q = ((64'd1 << exp_w) - 64'd1) << mant_w;
    q = q | (64'd1 << (mant_w - 1));
    return q;
  endfunction

endpackage

// File: rtl/fp_mul_special_pipe_if.sv
// Handshake and data bundle of the special-case front end.
// master = upstream/downstream environment, slave = the pipeline itself.
interface fp_mul_special_pipe_if #(
  parameter int unsigned W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic         out_valid;
  logic         out_ready;
  logic [4:0]   op1_status;
  logic [4:0]   op2_status;
  logic [3:0]   operation_status;
  logic         is_special;
  logic [W-1:0] special_result;
  logic         flags_clear;
  logic         flag_invalid;
  logic         flag_nan_in;
  logic         flag_denorm_in;

  modport master (
    output in_valid, op1, op2, out_ready, flags_clear,
    input  in_ready, out_valid, op1_status, op2_status, operation_status,
           is_special, special_result, flag_invalid, flag_nan_in, flag_denorm_in
  );

  modport slave (
    input  in_valid, op1, op2, out_ready, flags_clear,
    output in_ready, out_valid, op1_status, op2_status, operation_status,
           is_special, special_result, flag_invalid, flag_nan_in, flag_denorm_in
  );
endinterface

// File: rtl/fp_operand_classifier.sv
// Combinational IEEE-754 operand classifier producing the one-hot status
// {nan, inf, denormal, normal, zero}; DAZ folds denormals into zero.
module fp_operand_classifier
  import fp_mul_pkg::*;
#(
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned MANT_WIDTH = 23,
  parameter int unsigned DAZ        = 0
) (
  input  logic [EXP_WIDTH-1:0]  exp_field,
  input  logic [MANT_WIDTH-1:0] mant_field,
  output logic [4:0]            status,
  output logic                  denorm
);

  logic exp_ones, exp_zero, mant_zero;

  // Decode exponent/mantissa extremes into the operand class.
  always_comb begin
    exp_ones  = &exp_field;
    exp_zero  = ~|exp_field;
    mant_zero = ~|mant_field;
    denorm    = exp_zero & ~mant_zero;
    status    = '0;
    status[ST_NAN]    = exp_ones & ~mant_zero;
    status[ST_INF]    = exp_ones & mant_zero;
    status[ST_NORMAL] = ~exp_ones & ~exp_zero;
    status[ST_DENORM] = (DAZ == 0) ? denorm : 1'b0;
    status[ST_ZERO]   = exp_zero & (mant_zero | (DAZ != 0));
  end

endmodule

// File: rtl/fp_mul_special_pipe.sv
// Pipelined special-case front end for the IEEE-754 multiplier: classifies both
// operands, resolves NaN/inf/zero/invalid, builds the final special result word
// and keeps sticky exception flags. One global stall drives every stage.
module fp_mul_special_pipe
  import fp_mul_pkg::*;
#(
  parameter int unsigned IS_DOUBLE  = 0,
  parameter int unsigned EXP_WIDTH  = (IS_DOUBLE != 0) ? 11 : 8,
  parameter int unsigned MANT_WIDTH = (IS_DOUBLE != 0) ? 52 : 23,
  parameter int unsigned STAGES     = 2,
  parameter int unsigned DAZ        = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  fp_mul_special_pipe_if.slave bus
);

  localparam int unsigned W = EXP_WIDTH + MANT_WIDTH + 1;
  localparam logic [W-1:0] QNAN      = W'(make_qnan(EXP_WIDTH, MANT_WIDTH));
  localparam logic [W-1:0] QUIET_BIT = W'(1) << (MANT_WIDTH - 1);

  logic [4:0]   st1, st2;
  logic         den1, den2;
  logic         any_nan, inv, sgn;
  logic [3:0]   ops;
  stage_meta_t  meta_d;
  logic [W-1:0] res_d;
  logic         advance, out_valid, deliver;
  stage_meta_t  out_meta;
  logic         flag_invalid_q, flag_nan_q, flag_den_q;

  fp_operand_classifier #(
    .EXP_WIDTH  (EXP_WIDTH),
    .MANT_WIDTH (MANT_WIDTH),
    .DAZ        (DAZ)
  ) u_cls1 (
    .exp_field  (bus.op1[W-2 -: EXP_WIDTH]),
    .mant_field (bus.op1[MANT_WIDTH-1:0]),
    .status     (st1),
    .denorm     (den1)
  );

  fp_operand_classifier #(
    .EXP_WIDTH  (EXP_WIDTH),
    .MANT_WIDTH (MANT_WIDTH),
    .DAZ        (DAZ)
  ) u_cls2 (
    .exp_field  (bus.op2[W-2 -: EXP_WIDTH]),
    .mant_field (bus.op2[MANT_WIDTH-1:0]),
    .status     (st2),
    .denorm     (den2)
  );

  // Resolve the operation class and the prioritised special result word.
  always_comb begin
    any_nan = st1[ST_NAN] | st2[ST_NAN];
    inv     = (st1[ST_INF] & st2[ST_ZERO]) | (st2[ST_INF] & st1[ST_ZERO]);
    sgn     = bus.op1[W-1] ^ bus.op2[W-1];
    ops     = '0;
    ops[OP_INVALID] = inv;
    ops[OP_NAN]     = any_nan | inv;
    ops[OP_INF]     = (st1[ST_INF] | st2[ST_INF]) & ~any_nan & ~inv;
    ops[OP_ZERO]    = (st1[ST_ZERO] | st2[ST_ZERO]) & ~any_nan & ~inv;
    meta_d.st1       = st1;
    meta_d.st2       = st2;
    meta_d.ops       = ops;
    meta_d.denorm_in = den1 | den2;
    if (st1[ST_NAN]) begin
      res_d = bus.op1 | QUIET_BIT;
    end else if (st2[ST_NAN]) begin
      res_d = bus.op2 | QUIET_BIT;
    end else if (inv) begin
      res_d = QNAN;
    end else if (ops[OP_INF]) begin
      res_d = {sgn, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    end else if (ops[OP_ZERO]) begin
      res_d = {sgn, {(W-1){1'b0}}};
    end else begin
      res_d = '0;
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic         vld_q, vld_d;
    stage_meta_t  meta_q, meta_s;
    logic [W-1:0] res_q, res_s;

    if (g == 0) begin : g_src
      assign vld_d  = bus.in_valid;
      assign meta_s = meta_d;
      assign res_s  = res_d;
    end else begin : g_src
      assign vld_d  = g_stage[g-1].vld_q;
      assign meta_s = g_stage[g-1].meta_q;
      assign res_s  = g_stage[g-1].res_q;
    end

    // Shift one step on advance, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        meta_q <= '0;
        res_q  <= '0;
      end else if (advance) begin
        vld_q  <= vld_d;
        meta_q <= meta_s;
        res_q  <= res_s;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign out_meta  = g_stage[STAGES-1].meta_q;
  assign advance   = bus.out_ready | ~out_valid;
  assign deliver   = out_valid & bus.out_ready;

  // Sticky flags: a delivery sets, flags_clear clears, set wins on conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_invalid_q <= 1'b0;
      flag_nan_q     <= 1'b0;
      flag_den_q     <= 1'b0;
    end else begin
      flag_invalid_q <= (deliver & out_meta.ops[OP_INVALID]) |
                        (flag_invalid_q & ~bus.flags_clear);
      flag_nan_q     <= (deliver & (out_meta.st1[ST_NAN] | out_meta.st2[ST_NAN])) |
                        (flag_nan_q & ~bus.flags_clear);
      flag_den_q     <= (deliver & out_meta.denorm_in) | (flag_den_q & ~bus.flags_clear);
    end
  end

  assign bus.in_ready         = advance;
  assign bus.out_valid        = out_valid;
  assign bus.op1_status       = out_meta.st1;
  assign bus.op2_status       = out_meta.st2;
  assign bus.operation_status = out_meta.ops;
  assign bus.is_special       = |out_meta.ops;
  assign bus.special_result   = g_stage[STAGES-1].res_q;
  assign bus.flag_invalid     = flag_invalid_q;
  assign bus.flag_nan_in      = flag_nan_q;
  assign bus.flag_denorm_in   = flag_den_q;

endmodule

// File: tb/tb_fp_mul_special_pipe.sv
// Self-checking bench: two binary32 instances (DAZ=0 and DAZ=1) share stimulus;
// each has its own reference queue and sticky-flag model built from IEEE rules.
module tb_fp_mul_special_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, out_ready, flags_clear;
  logic [31:0] op1, op2;

  fp_mul_special_pipe_if #(.W(32)) bus_a ();
  fp_mul_special_pipe_if #(.W(32)) bus_b ();

  assign bus_a.in_valid    = in_valid;
  assign bus_a.op1         = op1;
  assign bus_a.op2         = op2;
  assign bus_a.out_ready   = out_ready;
  assign bus_a.flags_clear = flags_clear;
  assign bus_b.in_valid    = in_valid;
  assign bus_b.op1         = op1;
  assign bus_b.op2         = op2;
  assign bus_b.out_ready   = out_ready;
  assign bus_b.flags_clear = flags_clear;

  fp_mul_special_pipe #(.IS_DOUBLE(0), .STAGES(2), .DAZ(0)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  fp_mul_special_pipe #(.IS_DOUBLE(0), .STAGES(2), .DAZ(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [3:0]  ops;
    logic        spec;
    logic [31:0] res;
  } res_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] q_a[$];
  logic [63:0] q_b[$];
  logic [1:0]  mf_inv = '0, mf_nan = '0, mf_den = '0;
  logic [4:0]  cap_a_s1, cap_b_s1;
  logic        cap_a_spec;
  logic [31:0] cap_b_res;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Operand class straight from the IEEE encoding rules.
  function automatic logic [4:0] cls(input logic [31:0] x, input bit daz);
    int unsigned e, m;
    e = x[30:23];
    m = x[22:0];
    if (e == 255) return (m != 0) ? 5'b10000 : 5'b01000;
    if (e == 0) return (m == 0 || daz) ? 5'b00001 : 5'b00100;
    return 5'b00010;
  endfunction

  function automatic bit raw_den(input logic [31:0] x);
    return (x[30:23] == 8'h00) && (x[22:0] != 23'h0);
  endfunction

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input bit daz);
    res_t r;
    bit   n, iv, anyinf, anyzero, s;
    r.s1    = cls(a, daz);
    r.s2    = cls(b, daz);
    n       = r.s1[4] || r.s2[4];
    iv      = (r.s1[3] && r.s2[0]) || (r.s2[3] && r.s1[0]);
    anyinf  = r.s1[3] || r.s2[3];
    anyzero = r.s1[0] || r.s2[0];
    s       = a[31] ^ b[31];
    r.ops   = {n || iv, anyinf && !n && !iv, anyzero && !n && !iv, iv};
    r.spec  = (r.ops != 4'b0000);
    if (r.s1[4]) r.res = a | 32'h0040_0000;
    else if (r.s2[4]) r.res = b | 32'h0040_0000;
    else if (iv) r.res = 32'h7FC0_0000;
    else if (anyinf) r.res = s ? 32'hFF80_0000 : 32'h7F80_0000;
    else if (anyzero) r.res = s ? 32'h8000_0000 : 32'h0000_0000;
    else r.res = 32'h0;
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic        s;
    logic [22:0] m;
    s = 1'($urandom_range(1));
    m = 23'($urandom);
    case ($urandom_range(5))
      0: return {s, 8'h00, 23'h0};
      1: return {s, 8'hFF, 23'h0};
      2: return {s, 8'hFF, (m == 23'h0) ? 23'h1 : m};
      3: return {s, 8'h00, (m == 23'h0) ? 23'h1 : m};
      4: return {s, 8'($urandom_range(254, 1)), m};
      default: return $urandom;
    endcase
  endfunction

  // One negedge observation of one instance against its queue and flag model.
  task automatic mon_step(input int idx, input logic in_rdy, input logic out_v,
                          input logic [4:0] s1, input logic [4:0] s2, input logic [3:0] ops,
                          input logic spec, input logic [31:0] res,
                          input logic fi, input logic fn, input logic fd);
    string       p;
    res_t        e;
    logic [63:0] head;
    bit          have, si, sn, sd;
    p  = (idx == 1) ? "b" : "a";
    si = 0;
    sn = 0;
    sd = 0;
    if (!rst_n) begin
      if (idx == 1) q_b.delete();
      else q_a.delete();
      mf_inv[idx] = 1'b0;
      mf_nan[idx] = 1'b0;
      mf_den[idx] = 1'b0;
    end else begin
      check_eq({p, ".flag_invalid"}, 64'(fi), 64'(mf_inv[idx]));
      check_eq({p, ".flag_nan_in"}, 64'(fn), 64'(mf_nan[idx]));
      check_eq({p, ".flag_denorm_in"}, 64'(fd), 64'(mf_den[idx]));
      have = (idx == 1) ? (q_b.size() > 0) : (q_a.size() > 0);
      if (!have) begin
        check_eq({p, ".out_valid_idle"}, 64'(out_v), 64'd0);
      end else if (out_v) begin
        head = (idx == 1) ? q_b[0] : q_a[0];
        e = model(head[63:32], head[31:0], idx == 1);
        check_eq({p, ".op1_status"}, 64'(s1), 64'(e.s1));
        check_eq({p, ".op2_status"}, 64'(s2), 64'(e.s2));
        check_eq({p, ".operation_status"}, 64'(ops), 64'(e.ops));
        check_eq({p, ".is_special"}, 64'(spec), 64'(e.spec));
        check_eq({p, ".special_result"}, 64'(res), 64'(e.res));
        if (out_ready) begin
          if (idx == 1) void'(q_b.pop_front());
          else void'(q_a.pop_front());
          si = e.ops[0];
          sn = e.s1[4] || e.s2[4];
          sd = raw_den(head[63:32]) || raw_den(head[31:0]);
        end
      end
      mf_inv[idx] = si || (mf_inv[idx] && !flags_clear);
      mf_nan[idx] = sn || (mf_nan[idx] && !flags_clear);
      mf_den[idx] = sd || (mf_den[idx] && !flags_clear);
      if (in_valid && in_rdy) begin
        if (idx == 1) q_b.push_back({op1, op2});
        else q_a.push_back({op1, op2});
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, bus_a.in_ready, bus_a.out_valid, bus_a.op1_status, bus_a.op2_status,
             bus_a.operation_status, bus_a.is_special, bus_a.special_result,
             bus_a.flag_invalid, bus_a.flag_nan_in, bus_a.flag_denorm_in);
    mon_step(1, bus_b.in_ready, bus_b.out_valid, bus_b.op1_status, bus_b.op2_status,
             bus_b.operation_status, bus_b.is_special, bus_b.special_result,
             bus_b.flag_invalid, bus_b.flag_nan_in, bus_b.flag_denorm_in);
  end

  // Single pair with out_ready high: checks 2-cycle latency and the A-side result.
  task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic [3:0] eops,
                          input logic [31:0] eres, input bit clr);
    op1      = a;
    op2      = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check_eq("lat_early_a", 64'(bus_a.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check_eq("lat_a", 64'(bus_a.out_valid), 64'd1);
    check_eq("lat_b", 64'(bus_b.out_valid), 64'd1);
    check_eq("dir_ops_a", 64'(bus_a.operation_status), 64'(eops));
    check_eq("dir_res_a", 64'(bus_a.special_result), 64'(eres));
    cap_a_s1   = bus_a.op1_status;
    cap_a_spec = bus_a.is_special;
    cap_b_s1   = bus_b.op1_status;
    cap_b_res  = bus_b.special_result;
    if (clr) flags_clear = 1'b1;
    @(posedge clk);
    #1 flags_clear = 1'b0;
  endtask

  initial begin
    logic [31:0] sp1[6];
    logic [31:0] sp2[6];
    int          sent, cyc;
    logic        rdy;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    flags_clear = 1'b0;
    op1         = '0;
    op2         = '0;
    #2;
    check_eq("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check_eq("rst_op_status", 64'(bus_a.operation_status), 64'd0);
    check_eq("rst_op1_status", 64'(bus_a.op1_status), 64'd0);
    check_eq("rst_is_special", 64'(bus_a.is_special), 64'd0);
    check_eq("rst_result", 64'(bus_a.special_result), 64'd0);
    check_eq("rst_flags", 64'({bus_a.flag_invalid, bus_a.flag_nan_in, bus_a.flag_denorm_in}),
             64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check_eq("in_ready_after_rst", 64'(bus_a.in_ready), 64'd1);

    directed(32'h7F80_0000, 32'h0000_0000, 4'b1001, 32'h7FC0_0000, 1'b1);
    check_eq("inv_flag_set_wins", 64'(bus_a.flag_invalid), 64'd1);
    directed(32'h7F80_0001, 32'h3F80_0000, 4'b1000, 32'h7FC0_0001, 1'b0);
    check_eq("nan_flag", 64'(bus_a.flag_nan_in), 64'd1);
    directed(32'hC000_0000, 32'h7F80_0000, 4'b0100, 32'hFF80_0000, 1'b0);
    directed(32'h8000_0000, 32'h3F80_0000, 4'b0010, 32'h8000_0000, 1'b0);
    directed(32'h0000_0001, 32'h3F80_0000, 4'b0000, 32'h0000_0000, 1'b0);
    check_eq("denorm_status_a", 64'(cap_a_s1), 64'h04);
    check_eq("denorm_special_a", 64'(cap_a_spec), 64'd0);
    check_eq("daz_status_b", 64'(cap_b_s1), 64'h01);
    check_eq("daz_result_b", 64'(cap_b_res), 64'd0);
    check_eq("denorm_flag_a", 64'(bus_a.flag_denorm_in), 64'd1);
    check_eq("denorm_flag_b", 64'(bus_b.flag_denorm_in), 64'd1);

    // Back-to-back stream of 6 pairs with a 3-cycle downstream stall.
    for (int i = 0; i < 6; i++) begin
      sp1[i] = rand_op();
      sp2[i] = rand_op();
    end
    sent = 0;
    cyc  = 0;
    while (sent < 6 && cyc < 40) begin
      op1       = sp1[sent];
      op2       = sp2[sent];
      in_valid  = 1'b1;
      out_ready = !(cyc >= 3 && cyc < 6);
      #1 rdy = bus_a.in_ready;
      if (cyc >= 3 && cyc < 6) begin
        check_eq("stall_in_ready_a", 64'(rdy), 64'd0);
        check_eq("stall_in_ready_b", 64'(bus_b.in_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      if (rdy) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("stall_all_sent", 64'(sent), 64'd6);
    repeat (3) @(posedge clk);
    #1;
    check_eq("stall_drain_a", 64'(q_a.size()), 64'd0);
    check_eq("stall_drain_b", 64'(q_b.size()), 64'd0);

    // Random traffic with a reset pulse in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 202) rst_n = 1'b1;
      in_valid    = ($urandom_range(3) != 0);
      op1         = rand_op();
      op2         = rand_op();
      out_ready   = ($urandom_range(3) != 0);
      flags_clear = ($urandom_range(7) == 0);
      if (i == 200) begin
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid_a", 64'(bus_a.out_valid), 64'd0);
        check_eq("midrst_out_valid_b", 64'(bus_b.out_valid), 64'd0);
        check_eq("midrst_flags_a",
                 64'({bus_a.flag_invalid, bus_a.flag_nan_in, bus_a.flag_denorm_in}), 64'd0);
      end
      @(posedge clk);
      #1;
    end

    in_valid    = 1'b0;
    flags_clear = 1'b0;
    out_ready   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("final_drain_a", 64'(q_a.size()), 64'd0);
    check_eq("final_drain_b", 64'(q_b.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
